multi_edge_counter: RTL and testbench

//   Parametrised multi-channel edge detector and event counter. Successor to the

---
 rtl/multi_edge_counter.sv | 105 ++++++++++
 tb/tb_multi_edge_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_counter.sv
// multi_edge_counter: multi-channel edge detector and event counter.
// Each asynchronous input p[i] passes through a SYNC_STAGES-deep synchroniser
// into sclk. The edge type picked by EDGE_MODE is registered onto q[i]. The
// same edge is counted into cnt[i] when en is high. A sticky ovf[i] flag
// records counter overflow.
// Build option: define MULTI_EDGE_CNT_SAT_EN to make the counters saturate at
// all-ones. When it is left undefined, the counters wrap to zero.
// Legal parameter ranges: CH >= 1, CNT_W 2..32, SYNC_STAGES >= 2,
// EDGE_MODE 0 (rising), 1 (falling) or 2 (both).
`timescale 1ns/1ps

module multi_edge_counter #(
  parameter int CH          = 1,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic                sclk,
  input  logic                rst_n,
  input  logic [CH-1:0]       p,
  input  logic                en,
  input  logic                clr,
  output logic [CH*CNT_W-1:0] cnt,
  output logic [CH-1:0]       q,
  output logic [CH-1:0]       ovf
);

  logic [CH-1:0]    r_sync [SYNC_STAGES];  // r_sync[0] is the metastable stage
  logic [CH-1:0]    r_hist;                // previous synchronised value
  logic [CH-1:0]    r_q;
  logic [CH-1:0]    r_ovf;
  logic [CNT_W-1:0] r_cnt  [CH];

  logic [CH-1:0]    w_s;
  logic [CH-1:0]    w_edge;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchroniser chain and edge-history flop for every channel.
  // NOTE: non-blocking assignments let each stage take the previous stage's old value, so the chain shifts by one stage per clock; blocking assignments would collapse it into a single flop.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= p;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_hist <= w_s;
    end
  end

  // Select the configured edge term from the synchronised value and its history.
  // NOTE: w_edge receives a default before the case, so every path assigns it and no latch is inferred.
  always_comb begin
    w_edge = w_s ^ r_hist;
    case (EDGE_MODE)
      0:       w_edge = w_s & ~r_hist;
      1:       w_edge = ~w_s & r_hist;
      default: w_edge = w_s ^ r_hist;
    endcase
  end

  // Register the edge pulse. The pulse is not gated by en or clr.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= w_edge;
  end

  // Per-channel counters. clr has priority, then counting of enabled edges.
  // NOTE: the counter array is an array of flops rather than a RAM, so every entry is cleared by the async reset; reset-less storage would wake up with arbitrary counts.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (clr) begin
          r_cnt[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (en && w_edge[i]) begin
          if (&r_cnt[i]) begin
`ifdef MULTI_EDGE_CNT_SAT_EN
            r_cnt[i] <= r_cnt[i];      // stick at all-ones
`else
            r_cnt[i] <= '0;            // wrap to zero
`endif
            r_ovf[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Pack the per-channel counters onto the flat output bus.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < CH; i++) cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end

  assign q   = r_q;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_multi_edge_counter.sv
// Testbench for multi_edge_counter. Three instances share one set of inputs:
// one rising-edge, one falling-edge and one both-edge instance. A cycle table
// covers the common behaviour. Hand-written sequences cover the reset-release
// timing, toggle counting, wrap or saturation with clear, and reset asserted
// mid-count.
`timescale 1ns/1ps

module tb_multi_edge_counter;

  logic        sclk;
  logic        rst_n;
  logic [1:0]  p;
  logic        en;
  logic        clr;
  logic [15:0] cnt_r, cnt_f, cnt_b;
  logic [1:0]  q_r, q_f, q_b;
  logic [1:0]  ovf_r, ovf_f, ovf_b;

  int n_checks = 0;
  int n_fail   = 0;

  multi_edge_counter #(.CH(2), .CNT_W(8), .SYNC_STAGES(2), .EDGE_MODE(0)) u_rise (
    .sclk(sclk), .rst_n(rst_n), .p(p), .en(en), .clr(clr),
    .cnt(cnt_r), .q(q_r), .ovf(ovf_r));

  multi_edge_counter #(.CH(2), .CNT_W(8), .SYNC_STAGES(2), .EDGE_MODE(1)) u_fall (
    .sclk(sclk), .rst_n(rst_n), .p(p), .en(en), .clr(clr),
    .cnt(cnt_f), .q(q_f), .ovf(ovf_f));

  multi_edge_counter #(.CH(2), .CNT_W(8), .SYNC_STAGES(2), .EDGE_MODE(2)) u_both (
    .sclk(sclk), .rst_n(rst_n), .p(p), .en(en), .clr(clr),
    .cnt(cnt_b), .q(q_b), .ovf(ovf_b));

  initial begin
    sclk = 1'b0;
    forever #50 sclk = ~sclk;
  end

  typedef struct {
    logic [1:0] p;
    logic       en;
    logic       clr;
    logic [1:0] q_r;
    logic [1:0] q_f;
    logic [1:0] q_b;
    logic [7:0] c_r0;
    logic [7:0] c_r1;
    logic [7:0] c_b0;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // One rising pulse on channel 0: high for 2 cycles, then low for 2 cycles.
  task automatic pulse0();
    p = 2'b01; tick(); tick();
    p = 2'b00; tick(); tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cnt_r"}, cnt_r, 0);
    check({tag, " cnt_f"}, cnt_f, 0);
    check({tag, " cnt_b"}, cnt_b, 0);
    check({tag, " q_r"},   q_r,   0);
    check({tag, " q_b"},   q_b,   0);
    check({tag, " ovf_r"}, ovf_r, 0);
    check({tag, " ovf_b"}, ovf_b, 0);
  endtask

  initial begin
    int npulse;
    logic [7:0] exp_wrap_cnt;
    logic [7:0] exp_b_cnt;

    // Row r shows q for the input change made in row r-2.
    // The en and clr values of row r govern the count that is visible in row r.
    //            p      en    clr   q_r    q_f    q_b    cr0   cr1   cb0
    tbl[0]  = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0};
    tbl[1]  = '{2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0};
    tbl[2]  = '{2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0};
    tbl[3]  = '{2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 8'd1, 8'd0, 8'd1};
    tbl[4]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 8'd1};
    tbl[5]  = '{2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 8'd1};
    tbl[6]  = '{2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 8'd1, 8'd0, 8'd1};
    tbl[7]  = '{2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 8'd1};
    tbl[8]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 8'd1, 8'd0, 8'd2};
    tbl[9]  = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 8'd2};
    tbl[10] = '{2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 8'd0, 8'd0, 8'd0};
    tbl[11] = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 8'd0, 8'd0, 8'd1};
    tbl[12] = '{2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd1};
    tbl[13] = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd1};
    tbl[14] = '{2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 8'd1, 8'd0, 8'd2};
    tbl[15] = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 8'd1, 8'd0, 8'd3};
    tbl[16] = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 8'd3};
    tbl[17] = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 8'd3};
    tbl[18] = '{2'b11, 1'b1, 1'b0, 2'b11, 2'b00, 2'b11, 8'd2, 8'd1, 8'd4};
    tbl[19] = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'd2, 8'd1, 8'd4};

    // Reset state, then release of reset at 20 ns and a rising input at 45 ns.
    rst_n = 1'b0; p = 2'b00; en = 1'b1; clr = 1'b0;
    #10;
    check_all_zero("reset");
    #10 rst_n = 1'b1;
    #25 p = 2'b01;
    tick(); tick(); tick();           // now just after the 250 ns edge
    check("t1 q_r pulse", q_r, 2'b01);
    check("t1 q_b pulse", q_b, 2'b01);
    check("t1 q_f quiet", q_f, 2'b00);
    tick();
    check("t1 q_r one cycle", q_r, 2'b00);
    check("t1 cnt_r ch0", cnt_r[7:0], 8'd1);
    check("t1 cnt_r ch1", cnt_r[15:8], 8'd0);

    // Async reset asserted mid-cycle with non-zero counts, then released.
    p = 2'b00;
    repeat (4) tick();
    #20 rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    #10 rst_n = 1'b1;
    repeat (3) tick();

    // Cycle table.
    for (int r = 0; r < 20; r++) begin
      p = tbl[r].p; en = tbl[r].en; clr = tbl[r].clr;
      tick();
      check($sformatf("row%0d q_r", r),  q_r,         tbl[r].q_r);
      check($sformatf("row%0d q_f", r),  q_f,         tbl[r].q_f);
      check($sformatf("row%0d q_b", r),  q_b,         tbl[r].q_b);
      check($sformatf("row%0d cr0", r),  cnt_r[7:0],  tbl[r].c_r0);
      check($sformatf("row%0d cr1", r),  cnt_r[15:8], tbl[r].c_r1);
      check($sformatf("row%0d cb0", r),  cnt_b[7:0],  tbl[r].c_b0);
      check($sformatf("row%0d ovf", r),  {ovf_r, ovf_b}, 4'b0000);
    end
    en = 1'b1; clr = 1'b0;

    // Both-edge mode: 10 toggles, one every 4 cycles.
    p = 2'b00;
    repeat (4) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    npulse = 0;
    for (int t = 0; t < 10; t++) begin
      p[0] = ~p[0];
      for (int c = 0; c < 4; c++) begin
        tick();
        if (q_b[0]) npulse++;
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (q_b[0]) npulse++;
    end
    check("t2 q_b pulses", npulse, 10);
    check("t2 cnt_b ch0", cnt_b[7:0], 8'd10);
    check("t2 cnt_r ch0", cnt_r[7:0], 8'd5);
    check("t2 cnt_f ch0", cnt_f[7:0], 8'd5);
    check("t2 cnt_b ch1", cnt_b[15:8], 8'd0);

    // Wrap (or saturate) after 255 counted edges, then clear.
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (255) pulse0();
    repeat (3) tick();
    check("t4 cnt_r at max", cnt_r[7:0], 8'd255);
    check("t4 ovf_r before", ovf_r, 2'b00);
    pulse0();
    repeat (3) tick();
`ifdef MULTI_EDGE_CNT_SAT_EN
    exp_wrap_cnt = 8'd255;
    exp_b_cnt    = 8'd255;
`else
    exp_wrap_cnt = 8'd0;
    exp_b_cnt    = 8'd0;          // 512 edges wrap back to zero
`endif
    check("t4 cnt_r overflow", cnt_r[7:0], exp_wrap_cnt);
    check("t4 ovf_r set", ovf_r, 2'b01);
    check("t4 cnt_b overflow", cnt_b[7:0], exp_b_cnt);
    check("t4 ovf_b set", ovf_b, 2'b01);
    pulse0();
    repeat (3) tick();
    check("t4 cnt_r next", cnt_r[7:0], exp_wrap_cnt + 8'd1 - ((exp_wrap_cnt == 8'd255) ? 8'd1 : 8'd0));
    check("t4 ovf_r sticky", ovf_r, 2'b01);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t4 cnt_r clr", cnt_r[7:0], 8'd0);
    check("t4 ovf_r clr", ovf_r, 2'b00);
    check("t4 ovf_b clr", ovf_b, 2'b00);

    // Reset asserted mid-count while p[0] is held high, then released.
    repeat (7) pulse0();
    repeat (3) tick();
    check("t6 cnt_r pre", cnt_r[7:0], 8'd7);
    p = 2'b01;
    tick(); tick();
    #20 rst_n = 1'b0;
    #1;
    check_all_zero("t6 in reset");
    tick(); tick();
    check_all_zero("t6 held reset");
    #20 rst_n = 1'b1;
    npulse = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (q_r[0]) npulse++;
    end
    check("t6 q_r pulses", npulse, 1);
    check("t6 cnt_r ch0", cnt_r[7:0], 8'd1);
    check("t6 cnt_f ch0", cnt_f[7:0], 8'd0);
    check("t6 cnt_b ch0", cnt_b[7:0], 8'd1);
    check("t6 ovf_r", ovf_r, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
